// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch (IF) and load/store (LS).
// LS has priority, IF starvation is bounded, and misaligned accesses are rejected without touching memory.
`ifndef BYTE
`define BYTE     2'd0
`endif
`ifndef HALFWORD
`define HALFWORD 2'd1
`endif
`ifndef WORD
`define WORD     2'd2
`endif

module mem_port_arbiter #(
   parameter int MEM_LATENCY   = 2,
   parameter int MAX_LS_STREAK = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic        if_err,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [31:0] ls_addr,
   input  logic [1:0]  ls_how_much,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic        ls_err,
   output logic [31:0] ls_rdata,
   output logic [31:0] mem_addr,
   output logic [1:0]  mem_how_much,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, REJECT} state_t;

   state_t      state_reg, state_next;
   logic        owner_ls_reg, owner_ls_next;
   logic [31:0] addr_reg, addr_next;
   logic [1:0]  how_reg, how_next;
   logic        we_reg, we_next;
   logic [31:0] wdata_reg, wdata_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [3:0]  streak_reg, streak_next;
   logic        if_done_reg, if_done_next, if_err_reg, if_err_next;
   logic        ls_done_reg, ls_done_next, ls_err_reg, ls_err_next;
   logic [31:0] if_rdata_reg, if_rdata_next, ls_rdata_reg, ls_rdata_next;
   logic        grant_ls, grant_if, aligned;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         owner_ls_reg <= 1'b0;
         addr_reg     <= '0;
         how_reg      <= `WORD;
         we_reg       <= 1'b0;
         wdata_reg    <= '0;
         cnt_reg      <= '0;
         streak_reg   <= '0;
         if_done_reg  <= 1'b0;
         if_err_reg   <= 1'b0;
         ls_done_reg  <= 1'b0;
         ls_err_reg   <= 1'b0;
         if_rdata_reg <= '0;
         ls_rdata_reg <= '0;
      end else begin
         state_reg    <= state_next;
         owner_ls_reg <= owner_ls_next;
         addr_reg     <= addr_next;
         how_reg      <= how_next;
         we_reg       <= we_next;
         wdata_reg    <= wdata_next;
         cnt_reg      <= cnt_next;
         streak_reg   <= streak_next;
         if_done_reg  <= if_done_next;
         if_err_reg   <= if_err_next;
         ls_done_reg  <= ls_done_next;
         ls_err_reg   <= ls_err_next;
         if_rdata_reg <= if_rdata_next;
         ls_rdata_reg <= ls_rdata_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      owner_ls_next = owner_ls_reg;
      addr_next     = addr_reg;
      how_next      = how_reg;
      we_next       = we_reg;
      wdata_next    = wdata_reg;
      cnt_next      = cnt_reg;
      streak_next   = streak_reg;
      if_done_next  = 1'b0;
      if_err_next   = 1'b0;
      ls_done_next  = 1'b0;
      ls_err_next   = 1'b0;
      if_rdata_next = if_rdata_reg;
      ls_rdata_next = ls_rdata_reg;
      // IF overrides LS only once the streak has saturated while it waits
      grant_ls      = ls_req && !(if_req && (streak_reg == 4'(MAX_LS_STREAK)));
      grant_if      = if_req && !grant_ls;
      aligned       = 1'b1;

      unique case (state_reg)
         IDLE: begin
            if (grant_ls || grant_if) begin
               owner_ls_next = grant_ls;
               addr_next     = grant_ls ? ls_addr : if_addr;
               how_next      = grant_ls ? ls_how_much : `WORD;
               we_next       = grant_ls && ls_we;
               wdata_next    = grant_ls ? ls_wdata : '0;
               case (how_next)
                  `WORD:     aligned = (addr_next[1:0] == 2'b00);
                  `HALFWORD: aligned = (addr_next[0] == 1'b0);
                  default:   aligned = 1'b1;
               endcase
               state_next = aligned ? ACCESS : REJECT;
               cnt_next   = 4'(MEM_LATENCY - 1);
               if (grant_ls && if_req)
                  streak_next = (streak_reg == 4'(MAX_LS_STREAK)) ? streak_reg : streak_reg + 4'd1;
               else
                  streak_next = '0;
            end
         end
         ACCESS: begin
            if (cnt_reg == 4'd0) begin
               state_next = IDLE;
               if (owner_ls_reg) begin
                  ls_done_next = 1'b1;
                  if (!we_reg)
                     ls_rdata_next = mem_rdata;
               end else begin
                  if_done_next  = 1'b1;
                  if_rdata_next = mem_rdata;
               end
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         REJECT: begin
            state_next  = IDLE;
            if_err_next = !owner_ls_reg;
            ls_err_next = owner_ls_reg;
         end
         default: state_next = IDLE;
      endcase
   end

   assign mem_addr     = addr_reg;
   assign mem_how_much = how_reg;
   assign mem_wdata    = wdata_reg;
   assign mem_we       = (state_reg == ACCESS) && we_reg;
   assign if_done      = if_done_reg;
   assign if_err       = if_err_reg;
   assign ls_done      = ls_done_reg;
   assign ls_err       = ls_err_reg;
   assign if_rdata     = if_rdata_reg;
   assign ls_rdata     = ls_rdata_reg;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port between two requesters: the instruction-fetch stage (IF) and the load/store stage (LS).
- Owns the memory address, access size, write enable and write data for the duration of each access, and waits a fixed MEM_LATENCY cycles per access.
- Returns read data to the requester that issued the access.
- Arbitration gives LS priority, with a bound on how long IF can starve. Misaligned accesses are rejected without touching memory.

Parameters:
- MEM_LATENCY, 2: cycles from access issue to valid mem_rdata; legal range 1..15.
- MAX_LS_STREAK, 4: max consecutive LS grants while if_req is pending before IF is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  IF request; held high until if_done or if_err
- if_addr  in  word_address  fetch address; always a WORD access
- if_done  out  1  one-cycle pulse; if_rdata valid this cycle
- if_err  out  1  one-cycle pulse; misaligned fetch rejected
- if_rdata  out  word  fetched word; held until the next IF completion
- ls_req  in  1  LS request; held until ls_done or ls_err
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  word_address  load/store address
- ls_how_much  in  load_type  `BYTE / `HALFWORD / `WORD
- ls_wdata  in  word  store data, right-aligned
- ls_done  out  1  one-cycle completion pulse
- ls_err  out  1  one-cycle misalignment pulse
- ls_rdata  out  word  load data; held until the next LS completion
- mem_addr  out  word_address  to memory
- mem_how_much  out  load_type  to memory
- mem_we  out  1  to memory; high only in ACCESS for a store
- mem_wdata  out  word  to memory
- mem_rdata  in  word  from memory

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE; all done/err pulses 0; if_rdata=ls_rdata=0; mem_we=0; mem_addr=0; mem_how_much=`WORD; streak counter=0; latency counter=0.
- States: IDLE, ACCESS, REJECT.
- IDLE, arbitration:
  - If ls_req and if_req are both high and streak==MAX_LS_STREAK, IF wins. Otherwise LS wins whenever ls_req is high. Otherwise IF wins if if_req is high.
  - The winner's addr, how_much, we and wdata are latched. The winner is recorded in an owner register.
  - Alignment check: WORD needs addr[1:0]==0; HALFWORD needs addr[0]==0; BYTE is always legal. IF is always checked as WORD.
  - Aligned → ACCESS with counter=MEM_LATENCY-1. Misaligned → REJECT.
- ACCESS:
  - mem_* are driven from the latched registers.
  - Each cycle the counter decrements. At counter==0: assert owner's done; capture mem_rdata into owner's rdata (loads and fetches only; a store leaves ls_rdata unchanged); deassert mem_we; go to IDLE.
- REJECT: one cycle. Pulse owner's err; memory untouched (mem_we=0); go to IDLE.
- Streak counter:
  - Increments on each LS grant while if_req is high, saturating at MAX_LS_STREAK.
  - Clears on any IF grant, and on any LS grant while if_req is low.
- Latency: grant→done = MEM_LATENCY+1 cycles from the request's first visible cycle. There is one IDLE cycle between completions, so peak throughput is one access per MEM_LATENCY+1 cycles.
- Request rules:
  - A requester must not change its address or data while its req is high.
  - req deasserted before completion is a protocol violation; the access still completes and the pulse is still issued.
  - A requester may raise req again in the cycle after its done; it is seen at the next IDLE.
- Simultaneous events:
  - A new request arriving while in ACCESS waits; it is never dropped.
  - A done for one requester and a req from the other in the same cycle → the other is granted in the following IDLE cycle.
- Reset mid-access: the in-flight access is abandoned with no done pulse, mem_we drops immediately, and the streak is cleared.

Test Plan:
- Reset, then IF only: if_req, if_addr=0x10, mem_rdata=0x00000013 at MEM_LATENCY=2 → if_done pulse 3 cycles after if_req rises, if_rdata=0x00000013; ls_done stays 0.
- Simultaneous requests: if_req & ls_req (load, `WORD, 0x100) in the same cycle → LS served first, IF completes MEM_LATENCY+1 cycles after ls_done, streak returns to 0.
- Starvation bound: ls_req held continuously with back-to-back loads and if_req high, MAX_LS_STREAK=4 → exactly 4 ls_done, then if_done, then LS resumes.
- Store: ls_we=1, `BYTE, addr 0x203, wdata 0xAB → mem_we high for exactly MEM_LATENCY cycles with mem_addr=0x203, mem_how_much=`BYTE; ls_done pulses; ls_rdata unchanged.
- Misalignment: LS `HALFWORD at 0x101 → ls_err after 2 cycles, mem_we never asserted; IF at 0x6 → if_err.
- Reset mid-access: reset_n low during ACCESS of an LS load → no ls_done; outputs at reset values; the next request is served normally.
